// File: rtl/cpu_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge_pkg
// Shared definitions for the memory-side bridge of the 4-bit CPU core:
//   - ADDR_W_DEFAULT : default address / program-counter width
//   - nibble_t       : 4-bit data type carried on the CPU bus
//   - JMP_OVER_INC   : a jump beats the fetch increment when both strobe
//   - MAR_OVER_AUTOINC : an address-nibble shift beats the write
//                        auto-increment when both strobe
//   - PC_RST_VAL / ADDR_RST_VAL : reset values (sliced to ADDR_W by users)
// ---------------------------------------------------------------------------
package cpu_bus_bridge_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int NIBBLE_W       = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Strobe priority
    localparam bit JMP_OVER_INC     = 1'b1;
    localparam bit MAR_OVER_AUTOINC = 1'b1;

    // Reset values, wide enough for the largest supported ADDR_W (12)
    localparam logic [11:0] PC_RST_VAL   = 12'h000;
    localparam logic [11:0] ADDR_RST_VAL = 12'h000;

endpackage

// File: rtl/cpu_bus_nibble_ram.sv
// ---------------------------------------------------------------------------
// cpu_bus_nibble_ram
// Nibble-wide memory with one synchronous write port and one asynchronous
// read port. The read sees the contents before any write on the same edge,
// which gives read-before-write behaviour when the caller registers rdata_o.
// Contents are not reset.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write nibble
//   raddr_i  : read address
//   rdata_o  : read nibble (combinational)
// ---------------------------------------------------------------------------
module cpu_bus_nibble_ram
    import cpu_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  nibble_t           wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output nibble_t           rdata_o
);

    nibble_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge
// Memory-side stage downstream of the 4-bit CPU nibble bus. Owns the program
// counter, the address register, program memory and data memory, and
// returns one registered nibble per cycle on the CPU data inputs.
// Ports:
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   cpu_d      : CPU output nibble (data / address nibble)
//   cpu_mar    : shift cpu_d into the address register (MS nibble first)
//   cpu_write  : write cpu_d to dmem[addr]
//   cpu_jmp    : load pc from addr
//   cpu_i      : fetch pmem[pc] and advance pc
//   cpu_din    : registered nibble back to the CPU
//   prog_we/prog_addr/prog_data : host program-memory write port
//   pc, addr   : observe current program counter / address register
// Optional feature macro: CPU_BUS_BRIDGE_AUTOINC_EN
//   When defined, each write also increments addr unless MAR shifts it.
// ---------------------------------------------------------------------------
module cpu_bus_bridge
    import cpu_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int PDEPTH = 2**ADDR_W,
    parameter int DDEPTH = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        cpu_d,
    input  logic              cpu_mar,
    input  logic              cpu_write,
    input  logic              cpu_jmp,
    input  logic              cpu_i,
    output logic [3:0]        cpu_din,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [3:0]        prog_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    nibble_t           din_q, din_d;
    logic [ADDR_W-1:0] mar_shift;
    nibble_t           pmem_rdata;
    nibble_t           dmem_rdata;
    logic              dmem_we;

    // Address shift-in; a 4-bit address is simply replaced by each nibble.
    if (ADDR_W == 4) begin : g_mar_narrow
        assign mar_shift = cpu_d;
    end else begin : g_mar_wide
        assign mar_shift = {addr_q[ADDR_W-5:0], cpu_d};
    end

    // A write strobe caught by reset must not land in data memory.
    assign dmem_we = cpu_write & ~RST;

    cpu_bus_nibble_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (PDEPTH)
    ) u_pmem (
        .clk_i   (CLK),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (pmem_rdata)
    );

    cpu_bus_nibble_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DDEPTH)
    ) u_dmem (
        .clk_i   (CLK),
        .we_i    (dmem_we),
        .waddr_i (addr_q),
        .wdata_i (cpu_d),
        .raddr_i (addr_q),
        .rdata_o (dmem_rdata)
    );

    // All reads and the jump target use the pre-update pc/addr values.
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        din_d  = cpu_i ? pmem_rdata : dmem_rdata;

        if (cpu_jmp && (JMP_OVER_INC || !cpu_i)) begin
            pc_d = addr_q;
        end else if (cpu_i) begin
            pc_d = pc_q + ONE;
        end

`ifdef CPU_BUS_BRIDGE_AUTOINC_EN
        if (cpu_mar && (MAR_OVER_AUTOINC || !cpu_write)) begin
            addr_d = mar_shift;
        end else if (cpu_write) begin
            addr_d = addr_q + ONE;
        end
`else
        if (cpu_mar) begin
            addr_d = mar_shift;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q   <= PC_RST_VAL[ADDR_W-1:0];
            addr_q <= ADDR_RST_VAL[ADDR_W-1:0];
            din_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign cpu_din = din_q;
    assign pc      = pc_q;
    assign addr    = addr_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
module tb_cpu_bus_bridge;

    localparam int AW = 8;
    localparam int N  = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [3:0]    cpu_d;
    logic          cpu_mar, cpu_write, cpu_jmp, cpu_i;
    logic [3:0]    cpu_din;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_data;
    logic [AW-1:0] pc, addr;

    cpu_bus_bridge #(.ADDR_W(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu_d     (cpu_d),
        .cpu_mar   (cpu_mar),
        .cpu_write (cpu_write),
        .cpu_jmp   (cpu_jmp),
        .cpu_i     (cpu_i),
        .cpu_din   (cpu_din),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .pc        (pc),
        .addr      (addr)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers and arrays with validity flags.
    int m_pc, m_addr, m_din;
    bit m_din_known;
    int pm [N];
    bit pm_ok [N];
    int dm [N];
    bit dm_ok [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_addr = 0;
        m_din = 0;
        m_din_known = 1'b1;
    endtask

    // Effect of one clock edge given the inputs currently driven.
    task automatic model_step();
        int a0, p0;
        a0 = m_addr;
        p0 = m_pc;
        if (cpu_i) begin
            m_din = pm[p0];
            m_din_known = pm_ok[p0];
        end else begin
            m_din = dm[a0];
            m_din_known = dm_ok[a0];
        end
        if (cpu_write) begin
            dm[a0] = int'(cpu_d);
            dm_ok[a0] = 1'b1;
        end
        if (prog_we) begin
            pm[int'(prog_addr)] = int'(prog_data);
            pm_ok[int'(prog_addr)] = 1'b1;
        end
        if (cpu_jmp)
            m_pc = a0;
        else if (cpu_i)
            m_pc = (p0 + 1) % N;
        if (cpu_mar)
            m_addr = (a0 * 16 + int'(cpu_d)) % N;
`ifdef CPU_BUS_BRIDGE_AUTOINC_EN
        else if (cpu_write)
            m_addr = (a0 + 1) % N;
`endif
    endtask

    // Called at posedge+1; advances one edge and compares against the model.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("addr", 32'(addr), 32'(m_addr));
        if (m_din_known)
            check("cpu_din", 32'(cpu_din), 32'(m_din));
    endtask

    task automatic step(input logic [3:0] d, input logic mar, input logic wr,
                        input logic jmp, input logic i);
        cpu_d = d; cpu_mar = mar; cpu_write = wr; cpu_jmp = jmp; cpu_i = i;
        prog_we = 1'b0;
        cycle();
        $display("txn cpu d=%h mar=%b wr=%b jmp=%b i=%b -> pc=%h addr=%h din=%h",
                 d, mar, wr, jmp, i, pc, addr, cpu_din);
    endtask

    task automatic host(input int a, input int v);
        cpu_mar = 1'b0; cpu_write = 1'b0; cpu_jmp = 1'b0; cpu_i = 1'b0;
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = 4'(v);
        cycle();
        prog_we = 1'b0;
        $display("txn host pmem[%h]=%h -> pc=%h addr=%h", a, v, pc, addr);
    endtask

    // Reset asserted between edges with strobes still active.
    task automatic reset_mid(input string tag);
        #2 RST = 1'b1;
        #1;
        check({tag, "_pc_async"}, 32'(pc), 32'h0);
        check({tag, "_addr_async"}, 32'(addr), 32'h0);
        check({tag, "_din_async"}, 32'(cpu_din), 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        check({tag, "_pc_held"}, 32'(pc), 32'h0);
        check({tag, "_addr_held"}, 32'(addr), 32'h0);
        RST = 1'b0;
        cpu_mar = 1'b0; cpu_write = 1'b0; cpu_jmp = 1'b0; cpu_i = 1'b0; prog_we = 1'b0;
        $display("txn reset %s -> pc=%h addr=%h din=%h", tag, pc, addr, cpu_din);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pm_ok[k] = 1'b0;
            dm_ok[k] = 1'b0;
            pm[k] = 0;
            dm[k] = 0;
        end
        RST = 1'b1;
        cpu_d = 4'h0; cpu_mar = 1'b0; cpu_write = 1'b0; cpu_jmp = 1'b0; cpu_i = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = 4'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_din", 32'(cpu_din), 32'h0);
        RST = 1'b0;

        // Program load and three fetches
        host(0, 3); host(1, 4'hA); host(2, 5); host(3, 9); host(8'hFF, 4'hC);
        step(4'h0, 0, 0, 0, 1); check("fetch0", 32'(cpu_din), 32'h3);
        step(4'h0, 0, 0, 0, 1); check("fetch1", 32'(cpu_din), 32'hA);
        step(4'h0, 0, 0, 0, 1); check("fetch2", 32'(cpu_din), 32'h5);
        check("pc_after_fetch", 32'(pc), 32'h3);

        // Address build, data write, read back
        step(4'h4, 1, 0, 0, 0);
        step(4'h2, 1, 0, 0, 0); check("addr_42", 32'(addr), 32'h42);
        step(4'h7, 0, 1, 0, 0);
`ifdef CPU_BUS_BRIDGE_AUTOINC_EN
        check("autoinc_43", 32'(addr), 32'h43);
`else
        step(4'h0, 0, 0, 0, 0); check("dmem_42_rd", 32'(cpu_din), 32'h7);
`endif

        // Jump and fetch in the same cycle
        step(4'h1, 1, 0, 0, 0);
        step(4'h0, 1, 0, 0, 0); check("addr_10", 32'(addr), 32'h10);
        step(4'h0, 0, 0, 1, 1);
        check("jmp_fetch_din", 32'(cpu_din), 32'h9);
        check("jmp_fetch_pc", 32'(pc), 32'h10);

        // pc wrap at 0xFF
        step(4'hF, 1, 0, 0, 0);
        step(4'hF, 1, 0, 0, 0);
        step(4'h0, 0, 0, 1, 0); check("pc_ff", 32'(pc), 32'hFF);
        step(4'h0, 0, 0, 0, 1);
        check("wrap_din", 32'(cpu_din), 32'hC);
        check("wrap_pc", 32'(pc), 32'h0);

        // Write together with MAR shift
        step(4'h4, 1, 0, 0, 0);
        step(4'h2, 1, 0, 0, 0);
        step(4'h5, 1, 1, 0, 0); check("wr_mar_addr", 32'(addr), 32'h25);
        step(4'h4, 1, 0, 0, 0);
        step(4'h2, 1, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0); check("wr_mar_data", 32'(cpu_din), 32'h5);

        // Reset in the middle of a fetch sequence, memories retained
        step(4'h0, 0, 0, 0, 1);
        cpu_i = 1'b1; cpu_write = 1'b1; cpu_mar = 1'b1; cpu_d = 4'h6;
        reset_mid("mid");
        step(4'h0, 0, 0, 0, 1); check("post_reset_fetch", 32'(cpu_din), 32'h3);

        // Fill program memory, then randomized traffic
        for (int k = 0; k < N; k++)
            host(k, int'($urandom_range(0, 15)));
        for (int n = 0; n < 500; n++) begin
            cpu_d     = 4'($urandom_range(0, 15));
            cpu_mar   = ($urandom_range(0, 2) == 0);
            cpu_write = ($urandom_range(0, 2) == 0);
            cpu_jmp   = ($urandom_range(0, 5) == 0);
            cpu_i     = ($urandom_range(0, 1) == 0);
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = AW'($urandom_range(0, N - 1));
            prog_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                reset_mid("rand");
            end else begin
                cycle();
                $display("txn rand %0d -> pc=%h addr=%h din=%h", n, pc, addr, cpu_din);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
